// File: rtl/weight_mem_responder_if.sv
// Read bus between the encoder engines and the weight line buffer:
// request strobe/address out, line data/valid back.
interface weight_mem_responder_if #(
    parameter int BUS_WIDTH = 512
) ();
    logic                 mem_rd_en;
    logic [31:0]          mem_rd_addr;
    logic [BUS_WIDTH-1:0] mem_rd_data;
    logic                 mem_rd_valid;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        input  mem_rd_valid
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        output mem_rd_valid
    );
endinterface

// File: rtl/weight_mem_responder.sv
// On-chip weight line buffer: zeroed after reset, loaded by the host DMA,
// answers one line per read request after a fixed READ_LATENCY.
module weight_mem_responder #(
    parameter int          BUS_WIDTH    = 512,
    parameter int          DEPTH        = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter int          READ_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    weight_mem_responder_if.slave    rd_bus,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_index,
    input  logic [BUS_WIDTH-1:0]     wr_data,
    output logic                     ready,
    output logic                     rd_oob_err,
    input  logic                     err_clr,
    output logic [31:0]              rd_count
);
    localparam int BYTE_SHIFT = $clog2(BUS_WIDTH / 8);
    localparam int IDX_W      = $clog2(DEPTH);

    typedef enum logic {
        ST_CLEARING,
        ST_SERVING
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   clr_idx_reg, clr_idx_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_CLEARING;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            ST_CLEARING: begin
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == IDX_W'(DEPTH - 1))
                    state_next = ST_SERVING;
            end
            default: ;
        endcase
    end

    assign ready = (state_reg == ST_SERVING);

    // Address decode; the byte offset inside a line is discarded.
    logic [31:0]      addr_off;
    logic [31:0]      line_full;
    logic [IDX_W-1:0] rd_line;
    logic             rd_bad;

    assign addr_off  = rd_bus.mem_rd_addr - BASE_ADDR;
    assign line_full = addr_off >> BYTE_SHIFT;
    assign rd_line   = line_full[IDX_W-1:0];
    assign rd_bad    = (rd_bus.mem_rd_addr < BASE_ADDR) || (line_full >= 32'(DEPTH)) || !ready;

    // Single write port shared between the clear sweep and the loader.
    logic                 mem_we;
    logic [IDX_W-1:0]     mem_waddr;
    logic [BUS_WIDTH-1:0] mem_wdata;

    assign mem_we    = (state_reg == ST_CLEARING) || wr_en;
    assign mem_waddr = (state_reg == ST_CLEARING) ? clr_idx_reg : wr_index;
    assign mem_wdata = (state_reg == ST_CLEARING) ? '0 : wr_data;

    logic [BUS_WIDTH-1:0] mem [DEPTH];
    logic [BUS_WIDTH-1:0] ram_q_reg;

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        ram_q_reg <= mem[rd_line];
    end

    // First stage: the RAM read plus the bypass that gives write-first collisions.
    logic                 s0_valid_reg;
    logic                 s0_zero_reg;
    logic                 s0_byp_reg;
    logic [BUS_WIDTH-1:0] s0_byp_data_reg;
    logic [BUS_WIDTH-1:0] s0_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg <= 1'b0;
            s0_zero_reg  <= 1'b0;
            s0_byp_reg   <= 1'b0;
        end else begin
            s0_valid_reg <= rd_bus.mem_rd_en;
            s0_zero_reg  <= rd_bad;
            s0_byp_reg   <= ready && wr_en && (wr_index == rd_line);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            s0_byp_data_reg <= wr_data;
    end

    assign s0_data = s0_zero_reg ? '0 : (s0_byp_reg ? s0_byp_data_reg : ram_q_reg);

    logic                 out_valid;
    logic [BUS_WIDTH-1:0] out_data;

    generate
        if (READ_LATENCY == 1) begin : g_no_tail
            assign out_valid = s0_valid_reg;
            assign out_data  = s0_data;
        end else begin : g_tail
            logic                 tail_valid_reg [READ_LATENCY-1];
            logic [BUS_WIDTH-1:0] tail_data_reg  [READ_LATENCY-1];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < READ_LATENCY - 1; i++)
                        tail_valid_reg[i] <= 1'b0;
                end else begin
                    tail_valid_reg[0] <= s0_valid_reg;
                    for (int i = 1; i < READ_LATENCY - 1; i++)
                        tail_valid_reg[i] <= tail_valid_reg[i-1];
                end
            end

            // Data stages carry no reset so they can map onto shift-register primitives.
            always_ff @(posedge clk) begin
                tail_data_reg[0] <= s0_data;
                for (int i = 1; i < READ_LATENCY - 1; i++)
                    tail_data_reg[i] <= tail_data_reg[i-1];
            end

            assign out_valid = tail_valid_reg[READ_LATENCY-2];
            assign out_data  = tail_data_reg[READ_LATENCY-2];
        end
    endgenerate

    logic [BUS_WIDTH-1:0] hold_reg;

    always_ff @(posedge clk) begin
        if (rst)
            hold_reg <= '0;
        else if (out_valid)
            hold_reg <= out_data;
    end

    assign rd_bus.mem_rd_valid = out_valid;
    assign rd_bus.mem_rd_data  = out_valid ? out_data : hold_reg;

    // A new error outranks a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_oob_err <= 1'b0;
            rd_count   <= '0;
        end else begin
            if (rd_bus.mem_rd_en && rd_bad)
                rd_oob_err <= 1'b1;
            else if (err_clr)
                rd_oob_err <= 1'b0;
            if (rd_bus.mem_rd_en)
                rd_count <= rd_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_weight_mem_responder.sv
// Randomised bench for weight_mem_responder: a line-array reference model
// feeds a queue of expected responses that a negedge monitor consumes.
module tb_weight_mem_responder;
    localparam int          BW    = 512;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LAT   = 2;
    localparam int          LINE_BYTES = BW / 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           wr_en = 1'b0;
    logic [3:0]     wr_index = '0;
    logic [BW-1:0]  wr_data = '0;
    logic           ready;
    logic           rd_oob_err;
    logic           err_clr = 1'b0;
    logic [31:0]    rd_count;

    weight_mem_responder_if #(.BUS_WIDTH(BW)) bus ();

    weight_mem_responder #(
        .BUS_WIDTH(BW), .DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst), .rd_bus(bus),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .ready(ready), .rd_oob_err(rd_oob_err), .err_clr(err_clr), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [BW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [BW-1:0] ref_mem [DEPTH];
    int            clear_edges = 0;
    bit            m_err = 1'b0;
    logic [31:0]   m_cnt = '0;
    logic [BW-1:0] m_hold = '0;
    bit            mon_en = 1'b0;
    int            checks = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [BW-1:0] rnd_line();
        logic [BW-1:0] r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // One clock of stimulus; expectations come from the line-array model.
    task automatic cycle(input bit r, input bit en, input logic [31:0] addr,
                         input bit we, input logic [3:0] widx, input logic [BW-1:0] wd,
                         input bit clr);
        bit            m_ready;
        bit            bad;
        longint        line;
        logic [BW-1:0] exp_data;
        bit            nxt_err;
        exp_t          e;
        rst = r; bus.mem_rd_en = en; bus.mem_rd_addr = addr;
        wr_en = we; wr_index = widx; wr_data = wd; err_clr = clr;
        m_ready = (clear_edges >= DEPTH);
        nxt_err = m_err;
        if (!r) begin
            line = (addr < BASE) ? -1 : longint'(addr - BASE) / LINE_BYTES;
            bad  = (addr < BASE) || (line >= DEPTH) || !m_ready;
            if (en) begin
                if (bad)                               exp_data = '0;
                else if (we && widx == line[3:0])      exp_data = wd;
                else                                   exp_data = ref_mem[line[3:0]];
                e.data = exp_data;
                e.due  = edge_cnt + LAT;
                exp_q.push_back(e);
            end
            if (en && bad)  nxt_err = 1'b1;
            else if (clr)   nxt_err = 1'b0;
        end
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            clear_edges = 0; m_err = 1'b0; m_cnt = '0; m_hold = '0;
        end else begin
            if (we && m_ready) ref_mem[widx] = wd;
            if (clear_edges < DEPTH + 1) clear_edges++;
            m_err = nxt_err;
            if (en) m_cnt = m_cnt + 32'd1;
        end
        rst = 1'b0; bus.mem_rd_en = 1'b0; wr_en = 1'b0; err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 32'h0, 0, 4'h0, '0, 0);
    endtask

    task automatic rd(input logic [31:0] addr);
        cycle(0, 1, addr, 0, 4'h0, '0, 0);
    endtask

    task automatic wr(input logic [3:0] idx, input logic [BW-1:0] d);
        cycle(0, 0, 32'h0, 1, idx, d, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            chk("ready", BW'(ready), BW'(clear_edges >= DEPTH));
            chk("rd_oob_err", BW'(rd_oob_err), BW'(m_err));
            chk("rd_count", BW'(rd_count), BW'(m_cnt));
            if (exp_q.size() > 0 && exp_q[0].due < edge_cnt) begin
                checks++; failures++;
                $display("FAIL rd_missing actual=no_valid required=valid_at_edge_%0d", exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (bus.mem_rd_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL rd_spurious actual=valid required=no_valid edge=%0d", edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    chk("rd_latency", BW'(edge_cnt), BW'(e.due));
                    chk("rd_data", bus.mem_rd_data, e.data);
                    m_hold = e.data;
                    $display("rd_resp edge=%0d data_lo=%08h", edge_cnt, bus.mem_rd_data[31:0]);
                end
            end else begin
                chk("rd_hold", bus.mem_rd_data, m_hold);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [BW-1:0] pat;
        logic [31:0]   a;
        bus.mem_rd_en = 1'b0;
        bus.mem_rd_addr = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        cycle(1, 0, 32'h0, 0, 4'h0, '0, 0);
        cycle(1, 0, 32'h0, 0, 4'h0, '0, 0);
        mon_en = 1'b1;

        // Clear sweep; a read partway through is answered with zero and flags an error.
        idle(5);
        rd(BASE);
        cycle(0, 0, 32'h0, 0, 4'h0, '0, 1);
        idle(DEPTH);

        rd(BASE);
        idle(3);

        pat = {64{8'hA5}};
        wr(4'd3, pat);
        rd(BASE + 32'hC0);
        rd(BASE + 32'hC5);
        idle(3);

        for (int i = 0; i < 8; i++) wr(4'(i), rnd_line());
        for (int i = 0; i < 8; i++) rd(BASE + 32'(i * LINE_BYTES));
        idle(3);

        rd(BASE + 32'(DEPTH * LINE_BYTES));
        idle(1);
        cycle(0, 0, 32'h0, 0, 4'h0, '0, 1);
        rd(BASE - 32'd1);
        cycle(0, 1, BASE + 32'(DEPTH * LINE_BYTES), 0, 4'h0, '0, 1);
        cycle(0, 0, 32'h0, 0, 4'h0, '0, 1);
        idle(2);

        pat = '0;
        pat[15:0] = 16'h1234;
        cycle(0, 1, BASE + 32'(5 * LINE_BYTES), 1, 4'd5, pat, 0);
        idle(3);

        for (int n = 0; n < 300; n++) begin
            bit en;
            en = ($urandom % 4) != 0;
            if (($urandom % 10) < 8)
                a = BASE + 32'($urandom % DEPTH) * LINE_BYTES + 32'($urandom % LINE_BYTES);
            else if ($urandom % 2)
                a = BASE - 32'(1 + $urandom % 256);
            else
                a = BASE + 32'(DEPTH + $urandom % 8) * LINE_BYTES;
            cycle(0, en, a, bit'($urandom % 2), 4'($urandom % DEPTH), rnd_line(),
                  ($urandom % 8) == 0);
        end
        idle(3);

        // Reset with requests in flight: the pending one must never surface.
        rd(BASE + 32'(2 * LINE_BYTES));
        rd(BASE + 32'(3 * LINE_BYTES));
        cycle(1, 0, 32'h0, 0, 4'h0, '0, 0);
        idle(4);
        rd(BASE + 32'(1 * LINE_BYTES));
        idle(DEPTH + 2);
        rd(BASE + 32'(3 * LINE_BYTES));
        idle(LAT + 3);

        chk("queue_drained", BW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
